// File: rtl/tt_pkg.sv
// tt_pkg: shared encodings and sizes for the truth table checker.
package tt_pkg;
    localparam int N_IN = 4;
    localparam int N_CODES = 16;
    localparam int CNT_W = 5;
    localparam int TIMER_W = 8;
    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;
endpackage

// File: rtl/settle_timer.sv
// settle_timer: loadable down-counter that parks at zero.
module settle_timer
    import tt_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               en,
    input  logic [TIMER_W-1:0] load_val,
    output logic               zero
);
    logic [TIMER_W-1:0] count;
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (load) count <= load_val;
        else if (en && !zero) count <= count - 1'b1;
    assign zero = count == '0;
endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps a 4-input code, samples f after a settle time and
// compares the captured truth table against EXPECTED.
module truth_table_checker
    import tt_pkg::*;
#(
    parameter int                  SETTLE   = 20,
    parameter logic [N_CODES-1:0]  EXPECTED = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               d,
    input  logic               f,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [N_CODES-1:0] table_out,
    output logic [CNT_W-1:0]   mismatch_cnt,
    output logic [N_IN-1:0]    fail_idx
);
    localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(SETTLE - 1);
    state_t          state;
    logic [N_IN-1:0] code;
    logic            timer_zero;
    logic            load;
    logic            mis;
    assign load = (state == IDLE && start) || (state == SAMPLE && code != '1);
    assign mis = f != EXPECTED[code];
    assign {a, b, c, d} = code;
    settle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .en       (state == WAIT),
        .load_val (LOAD_VAL),
        .zero     (timer_zero)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state        <= IDLE;
            code         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            table_out    <= '0;
            mismatch_cnt <= '0;
            fail_idx     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    code         <= '0;
                    table_out    <= '0;
                    mismatch_cnt <= '0;
                    fail_idx     <= '0;
                    pass         <= 1'b0;
                    busy         <= 1'b1;
                    state        <= WAIT;
                end
                WAIT: if (timer_zero) state <= SAMPLE;
                SAMPLE: begin
                    table_out[code] <= f;
                    if (mis) begin
                        mismatch_cnt <= mismatch_cnt + 1'b1;
                        if (mismatch_cnt == '0) fail_idx <= code;
                    end
                    if (code == '1) state <= DONE;
                    else begin
                        code  <= code + 1'b1;
                        state <= WAIT;
                    end
                end
                DONE: begin
                    // mismatch_cnt already holds the final count here
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= mismatch_cnt == '0;
                    code  <= '0;
                    state <= IDLE;
                end
            endcase
        end
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: scoreboard bench driving a behavioural combinational DUT.
module tb_truth_table_checker;
    localparam int SETTLE = 2;
    localparam logic [15:0] EXP = 16'hA5C3;
    localparam int LAT = 16 * (SETTLE + 1) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    wire  f;
    wire  a, b, c, d, busy, done, pass;
    wire  [15:0] table_out;
    wire  [4:0]  mismatch_cnt;
    wire  [3:0]  fail_idx;
    int mode = 0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_done;

    typedef struct {
        logic [15:0] tbl;
        logic [4:0]  cnt;
        logic [3:0]  fidx;
        logic        pas;
        int          acc;
    } exp_t;
    exp_t q[$];

    truth_table_checker #(.SETTLE(SETTLE), .EXPECTED(EXP)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a(a), .b(b), .c(c), .d(d), .f(f),
        .busy(busy), .done(done), .pass(pass),
        .table_out(table_out), .mismatch_cnt(mismatch_cnt), .fail_idx(fail_idx)
    );

    always #5 clk = ~clk;
    always_ff @(posedge clk) cyc <= cyc + 1;

    // mode 0 golden, 1 tied 0, 2 golden with code 9 inverted, 3 tied 1
    function automatic logic model_f(int m, logic [3:0] k);
        return m == 1 ? 1'b0 : m == 3 ? 1'b1 : EXP[k] ^ (m == 2 && k == 4'd9);
    endfunction
    assign f = model_f(mode, {a, b, c, d});

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic exp_t predict(int m, int acc);
        exp_t e;
        e.tbl = '0;
        e.cnt = '0;
        e.fidx = '0;
        e.acc = acc;
        for (int i = 0; i < 16; i++) begin
            e.tbl[i] = model_f(m, 4'(i));
            if (e.tbl[i] != EXP[i]) begin
                if (e.cnt == 0) e.fidx = 4'(i);
                e.cnt++;
            end
        end
        e.pas = e.cnt == 0;
        return e;
    endfunction

    always @(negedge clk) if (done) begin
        if (q.size() == 0) check("spurious_done", 1, 0);
        else begin
            exp_t e;
            e = q.pop_front();
            check("latency", cyc - e.acc, LAT);
            check("sb_table", table_out, e.tbl);
            check("sb_cnt", mismatch_cnt, e.cnt);
            check("sb_fail_idx", fail_idx, e.fidx);
            check("sb_pass", pass, e.pas);
            check("sb_busy_low", busy, 0);
        end
    end

    // called at a negedge; start is sampled on the following edge
    task automatic run_start(int m);
        mode = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        q.push_back(predict(m, cyc));
        check("acc_busy", busy, 1);
        check("acc_cnt", mismatch_cnt, 0);
        check("acc_table", table_out, 0);
        check("acc_pass", pass, 0);
    endtask

    task automatic wait_done(string tag);
        for (int i = 0; i < LAT + 10; i++) begin
            @(negedge clk);
            if (done) return;
        end
        check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_abcd", {a, b, c, d}, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_table", table_out, 0);
        check("rst_cnt", mismatch_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        run_start(0);
        wait_done("s1");
        check("s1_pass", pass, 1);
        check("s1_table", table_out, 16'hA5C3);
        check("s1_cnt", mismatch_cnt, 0);
        repeat (3) @(negedge clk);
        check("s1_hold_pass", pass, 1);
        check("s1_hold_table", table_out, 16'hA5C3);
        check("s1_idle_abcd", {a, b, c, d}, 0);

        run_start(1);
        wait_done("s2");
        check("s2_pass", pass, 0);
        check("s2_table", table_out, 16'h0000);
        check("s2_cnt", mismatch_cnt, 8);
        check("s2_fail_idx", fail_idx, 0);
        @(negedge clk);

        run_start(2);
        wait_done("s3");
        check("s3_pass", pass, 0);
        check("s3_cnt", mismatch_cnt, 1);
        check("s3_fail_idx", fail_idx, 9);
        check("s3_table", table_out, 16'hA7C3);
        @(negedge clk);

        run_start(0);
        n_done = 0;
        for (int i = 1; i <= LAT + 5; i++) begin
            start = (i == 5 || i == 30);
            @(negedge clk);
            if (done) n_done++;
        end
        start = 1'b0;
        check("s4_done_count", n_done, 1);
        check("s4_pass", pass, 1);
        check("s4_table", table_out, 16'hA5C3);
        check("s4_busy", busy, 0);

        run_start(0);
        for (int i = 0; i < 200 && {a, b, c, d} != 4'd7; i++) @(negedge clk);
        check("s5_reach7", {a, b, c, d}, 7);
        #2 rst = 1'b1;
        #1;
        check("s5_abcd", {a, b, c, d}, 0);
        check("s5_busy", busy, 0);
        check("s5_done", done, 0);
        check("s5_pass", pass, 0);
        check("s5_table", table_out, 0);
        check("s5_cnt", mismatch_cnt, 0);
        check("s5_fail_idx", fail_idx, 0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_start(0);
        wait_done("s5b");
        check("s5b_pass", pass, 1);
        check("s5b_table", table_out, 16'hA5C3);

        run_start(3);
        wait_done("s6");
        check("s6_table", table_out, 16'hFFFF);
        check("s6_cnt", mismatch_cnt, 8);
        check("s6_fail_idx", fail_idx, 2);
        check("s6_pass", pass, 0);
        repeat (3) @(negedge clk);
        check("sb_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
Response-side counterpart to the team's exhaustive 4-input combinational stimulus benches.
- Steps a 4-bit input code {a,b,c,d} through 0..15 to drive a combinational DUT.
- Waits a programmable settle time at each code, then samples the DUT output f.
- Builds the captured 16-entry truth table and compares it bit-by-bit against an expected table.
- Reports pass/fail, mismatch count and first failing code. Usable in simulation and on-board self-test.

Parameters:
SETTLE, 20, cycles held at each code before sampling f; legal range 1..255.
EXPECTED, 16'h0000, expected truth table; bit i is the required f for code i.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  begin a run; sampled only in IDLE
a  output  1  DUT input, code bit 3 (MSB)
b  output  1  DUT input, code bit 2
c  output  1  DUT input, code bit 1
d  output  1  DUT input, code bit 0 (LSB)
f  input  1  DUT combinational output
busy  output  1  high from accepted start until DONE is exited
done  output  1  one-cycle pulse at end of run
pass  output  1  1 if last run had zero mismatches; held until next start
table_out  output  16  captured truth table, bit i = f sampled at code i
mismatch_cnt  output  5  number of mismatching codes, 0..16
fail_idx  output  4  lowest code that mismatched; meaningful only when pass=0 after done

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; a,b,c,d=0; busy=0; done=0; pass=0; table_out=0; mismatch_cnt=0; fail_idx=0; timer=0. All take effect immediately, including mid-run.
- IDLE, start=1 at edge E:
  - code=0, table_out=0, mismatch_cnt=0, fail_idx=0, pass=0, busy=1.
  - timer=SETTLE-1; go to WAIT.
- WAIT: {a,b,c,d}=code, held stable.
  - timer decrements each cycle.
  - When timer==0, go to SAMPLE on the next edge.
  - WAIT therefore lasts SETTLE cycles.
- SAMPLE (one cycle), at the edge leaving SAMPLE:
  - table_out[code]=f.
  - If f != EXPECTED[code]: mismatch_cnt+1; if this is the first mismatch, fail_idx=code.
  - If code==15, go to DONE. Otherwise code+1, timer=SETTLE-1, go to WAIT.
  - a..d change only on this edge; no wrap past 15.
- Timing: each code occupies SETTLE+1 cycles. The last SAMPLE ends 16*(SETTLE+1) cycles after E.
- DONE (one cycle):
  - done=1, busy=0.
  - pass=(mismatch_cnt==0), evaluated on the final count.
  - Next state IDLE.
  - a..d return to 0 in IDLE.
- After DONE: table_out, mismatch_cnt, fail_idx and pass hold until the next accepted start.
- start while busy, or in DONE: ignored, with no restart and no extra done.
- start held high continuously: a new run is accepted on the first IDLE cycle after DONE.
- Simultaneous rst and start: rst wins.

Decomposition:
- Shared package tt_pkg:
  - state encoding IDLE/WAIT/SAMPLE/DONE (2 bits);
  - localparams N_IN=4 and N_CODES=16;
  - mismatch counter width 5.
- One sub-module, settle_timer:
  - 8-bit loadable down-counter with load, load_val and zero outputs;
  - resets to 0 on asynchronous rst.
- Top module holds the FSM, code counter and result registers.

Test Plan:
1. EXPECTED=16'hA5C3, SETTLE=2, golden model f=EXPECTED[{a,b,c,d}], start pulsed -> done pulse 49 cycles after the start edge; pass=1, table_out=16'hA5C3, mismatch_cnt=0.
2. Same parameters, f tied 0 -> pass=0, table_out=16'h0000, mismatch_cnt=8, fail_idx=0.
3. Golden model with f inverted only at code 9 -> pass=0, mismatch_cnt=1, fail_idx=9, table_out=16'hA7C3.
4. start re-pulsed at cycles 5 and 30 of a run -> ignored; exactly one done pulse at cycle 49; results as in scenario 1.
5. rst asserted while code=7 -> all outputs at reset values in the same cycle (asynchronous); a fresh start then completes as scenario 1.
6. Second start on the cycle after done, with f tied 1 -> first cycle after acceptance shows mismatch_cnt=0 and table_out=0; at completion table_out=16'hFFFF, mismatch_cnt=8, fail_idx=2.
